// File: rtl/ifu_imem_slave.sv
// Read-only AXI-lite instruction memory for the IFU: in-order R beats, up to OUTSTANDING queued ARs.
// AR accept to rvalid is LATENCY+2 cycles; arready drops when the queue is full, R beat held until rready.
module ifu_imem_slave #(
    parameter int          AW          = 12,
    parameter logic [63:0] ADDR_BASE   = 64'h8000_0000,
    parameter int          OUTSTANDING = 4,
    parameter int          LATENCY     = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ifu_arvalid,
    output logic          ifu_arready,
    input  logic [63:0]   ifu_araddr,
    output logic          ifu_rvalid,
    input  logic          ifu_rready,
    output logic [1:0]    ifu_rresp,
    output logic [31:0]   ifu_rdata,
    input  logic          load_en,
    input  logic [AW-1:0] load_addr,
    input  logic [31:0]   load_data,
    output logic [2:0]    pend_cnt
);
    localparam int PW = $clog2(OUTSTANDING);
    localparam int CW = PW + 1;
    localparam int LW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    // One bit wider than the address so the upper bound never wraps.
    localparam logic [64:0] ADDR_LIMIT = {1'b0, ADDR_BASE} + (65'd4 << AW);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    logic [31:0]   mem [2**AW];
    logic [AW+1:0] q_mem [OUTSTANDING];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] q_cnt;
    logic [1:0]    state;
    logic [LW-1:0] lat_cnt;
    logic [AW-1:0] cur_idx;
    logic [1:0]    cur_err;
    logic          q_full;
    logic          q_empty;
    logic          push;
    logic          pop;
    logic          r_hs;
    logic [1:0]    ar_err;
    logic [AW-1:0] ar_idx;

    assign q_full      = (q_cnt == CW'(OUTSTANDING));
    assign q_empty     = (q_cnt == '0);
    assign ifu_arready = rst_n && !q_full;
    assign push        = ifu_arvalid && ifu_arready;
    assign r_hs        = ifu_rvalid && ifu_rready;
    assign pop         = !q_empty && ((state == S_IDLE) || (state == S_RESP && r_hs));

    always_comb begin
        ar_err = RESP_OKAY;
        if (ifu_araddr[1:0] != 2'b00) begin
            ar_err = RESP_SLVERR;
        end else if ((ifu_araddr < ADDR_BASE) || ({1'b0, ifu_araddr} >= ADDR_LIMIT)) begin
            ar_err = RESP_DECERR;
        end
    end

    // Only the low address bits matter for the word offset of an in-range access.
    assign ar_idx = ifu_araddr[AW+1:2] - ADDR_BASE[AW+1:2];

    always_ff @(posedge clk) begin
        if (load_en) begin
            mem[load_addr] <= load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_mem[wr_ptr] <= {ar_idx, ar_err};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            q_cnt  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   q_cnt <= q_cnt + CW'(1);
                2'b01:   q_cnt <= q_cnt - CW'(1);
                default: q_cnt <= q_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            lat_cnt    <= '0;
            cur_idx    <= '0;
            cur_err    <= RESP_OKAY;
            ifu_rvalid <= 1'b0;
            ifu_rresp  <= RESP_OKAY;
            ifu_rdata  <= '0;
        end else begin
            if (pop) begin
                {cur_idx, cur_err} <= q_mem[rd_ptr];
                lat_cnt            <= LW'(LATENCY - 1);
            end
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        state <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (lat_cnt != '0) begin
                        lat_cnt <= lat_cnt - LW'(1);
                    end else begin
                        ifu_rvalid <= 1'b1;
                        ifu_rresp  <= cur_err;
                        ifu_rdata  <= (cur_err == RESP_OKAY) ? mem[cur_idx] : 32'h0;
                        state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (r_hs) begin
                        ifu_rvalid <= 1'b0;
                        state      <= pop ? S_BUSY : S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_cnt <= '0;
        end else if (push && !r_hs) begin
            pend_cnt <= pend_cnt + 3'd1;
        end else if (r_hs && !push) begin
            pend_cnt <= pend_cnt - 3'd1;
        end
    end

endmodule

// File: tb/tb_ifu_imem_slave.sv
// Directed bench for ifu_imem_slave: a LATENCY=1 instance for the main sequence and a LATENCY=3 instance.
module tb_ifu_imem_slave;
    localparam logic [63:0] BASE = 64'h8000_0000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        ifu_arvalid, ifu_arready, ifu_rvalid, ifu_rready, load_en;
    logic [63:0] ifu_araddr;
    logic [1:0]  ifu_rresp;
    logic [31:0] ifu_rdata, load_data;
    logic [11:0] load_addr;
    logic [2:0]  pend_cnt;

    logic        ifu_arvalid_3, ifu_arready_3, ifu_rvalid_3, ifu_rready_3, load_en_3;
    logic [63:0] ifu_araddr_3;
    logic [1:0]  ifu_rresp_3;
    logic [31:0] ifu_rdata_3, load_data_3;
    logic [11:0] load_addr_3;
    logic [2:0]  pend_cnt_3;

    int checks = 0;
    int errors = 0;

    ifu_imem_slave #(.AW(12), .ADDR_BASE(BASE), .OUTSTANDING(4), .LATENCY(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_arvalid(ifu_arvalid), .ifu_arready(ifu_arready), .ifu_araddr(ifu_araddr),
        .ifu_rvalid(ifu_rvalid), .ifu_rready(ifu_rready), .ifu_rresp(ifu_rresp), .ifu_rdata(ifu_rdata),
        .load_en(load_en), .load_addr(load_addr), .load_data(load_data), .pend_cnt(pend_cnt)
    );

    ifu_imem_slave #(.AW(12), .ADDR_BASE(BASE), .OUTSTANDING(4), .LATENCY(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .ifu_arvalid(ifu_arvalid_3), .ifu_arready(ifu_arready_3), .ifu_araddr(ifu_araddr_3),
        .ifu_rvalid(ifu_rvalid_3), .ifu_rready(ifu_rready_3), .ifu_rresp(ifu_rresp_3), .ifu_rdata(ifu_rdata_3),
        .load_en(load_en_3), .load_addr(load_addr_3), .load_data(load_data_3), .pend_cnt(pend_cnt_3)
    );

    function automatic logic [31:0] img(input int i);
        case (i)
            0:       img = 32'h0000_0413;
            1:       img = 32'h1111_1111;
            2:       img = 32'h2222_2222;
            3:       img = 32'h3333_3333;
            4:       img = 32'h4444_4444;
            7:       img = 32'h7777_7777;
            4095:    img = 32'hDEAD_BEEF;
            default: img = 32'h0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load1(input logic [11:0] idx, input logic [31:0] dat);
        load_en = 1'b1; load_addr = idx; load_data = dat;
        tick;
        load_en = 1'b0;
    endtask

    task automatic load3(input logic [11:0] idx, input logic [31:0] dat);
        load_en_3 = 1'b1; load_addr_3 = idx; load_data_3 = dat;
        tick;
        load_en_3 = 1'b0;
    endtask

    task automatic single_read(input string tag, input logic [63:0] addr,
                               input logic [1:0] exp_resp, input logic [31:0] exp_data);
        int n;
        ifu_arvalid = 1'b1; ifu_araddr = addr; ifu_rready = 1'b1;
        tick;
        ifu_arvalid = 1'b0;
        n = 1;
        while (!ifu_rvalid && n < 20) begin
            tick;
            n++;
        end
        chk({tag, "_lat"}, 64'(n), 64'd3);
        chk({tag, "_resp"}, 64'(ifu_rresp), 64'(exp_resp));
        chk({tag, "_data"}, 64'(ifu_rdata), 64'(exp_data));
        tick;
        chk({tag, "_drop"}, 64'(ifu_rvalid), 64'd0);
        chk({tag, "_pend"}, 64'(pend_cnt), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int beats;
        rst_n = 1'b0;
        ifu_arvalid = 1'b0; ifu_araddr = '0; ifu_rready = 1'b0;
        load_en = 1'b0; load_addr = '0; load_data = '0;
        ifu_arvalid_3 = 1'b0; ifu_araddr_3 = '0; ifu_rready_3 = 1'b0;
        load_en_3 = 1'b0; load_addr_3 = '0; load_data_3 = '0;

        // Reset state; array loaded while reset is held
        tick;
        tick;
        chk("rst_arready", 64'(ifu_arready), 64'd0);
        chk("rst_rvalid", 64'(ifu_rvalid), 64'd0);
        chk("rst_rresp", 64'(ifu_rresp), 64'd0);
        chk("rst_rdata", 64'(ifu_rdata), 64'd0);
        chk("rst_pend", 64'(pend_cnt), 64'd0);
        for (int i = 0; i < 5; i++) load1(12'(i), img(i));
        load1(12'd7, img(7));
        load1(12'd4095, img(4095));
        load3(12'd5, 32'h5555_5555);
        rst_n = 1'b1;
        tick;
        chk("rst_arready_up", 64'(ifu_arready), 64'd1);

        // Single read, latency 3
        single_read("t1", BASE, 2'b00, img(0));

        // Four back-to-back reads, one beat every two cycles
        ifu_rready = 1'b1;
        n = 0;
        for (int c = 0; c < 14; c++) begin
            if (c < 4) begin
                ifu_arvalid = 1'b1;
                ifu_araddr = BASE + 64'(4 * c);
            end else begin
                ifu_arvalid = 1'b0;
            end
            if (ifu_rvalid) begin
                chk("t2_data", 64'(ifu_rdata), 64'(img(n)));
                chk("t2_cyc", 64'(c), 64'(3 + 2 * n));
                n++;
            end
            tick;
        end
        chk("t2_beats", 64'(n), 64'd4);
        chk("t2_pend", 64'(pend_cnt), 64'd0);

        // Error decode and upper boundary
        single_read("t3_mis", BASE + 64'd2, 2'b10, 32'h0);
        single_read("t3_hi", BASE + 64'h4000, 2'b11, 32'h0);
        single_read("t3_lo", 64'h7FFF_FFFC, 2'b11, 32'h0);
        single_read("t3_last", BASE + 64'h3FFC, 2'b00, img(4095));

        // rready stall: beat held, queue fills, then drains in order
        n = 0;
        for (int c = 0; c < 24; c++) begin
            ifu_arvalid = (c <= 6);
            ifu_araddr = (c < 5) ? BASE + 64'(4 * c) : BASE + 64'd28;
            ifu_rready = (c >= 8);
            if (c >= 3 && c <= 7) begin
                chk("t4_hold_vld", 64'(ifu_rvalid), 64'd1);
                chk("t4_hold_dat", 64'(ifu_rdata), 64'(img(0)));
                chk("t4_hold_rsp", 64'(ifu_rresp), 64'd0);
            end
            if (c == 5) begin
                chk("t4_full_rdy", 64'(ifu_arready), 64'd0);
                chk("t4_full_pend", 64'(pend_cnt), 64'd5);
            end
            if (c == 7) chk("t4_nopush", 64'(pend_cnt), 64'd5);
            if (ifu_rvalid && ifu_rready) begin
                chk("t4_data", 64'(ifu_rdata), 64'(img(n)));
                chk("t4_cyc", 64'(c), 64'(8 + 2 * n));
                n++;
            end
            tick;
        end
        chk("t4_beats", 64'(n), 64'd5);
        chk("t4_pend", 64'(pend_cnt), 64'd0);

        // Simultaneous push and R handshake, then reset with requests pending
        for (int c = 0; c < 5; c++) begin
            ifu_arvalid = (c <= 3);
            ifu_araddr = BASE + 64'(4 * c);
            ifu_rready = (c == 3);
            if (c == 3) begin
                chk("t5_vld", 64'(ifu_rvalid), 64'd1);
                chk("t5_dat", 64'(ifu_rdata), 64'(img(0)));
                chk("t5_pend_before", 64'(pend_cnt), 64'd3);
            end
            if (c == 4) begin
                chk("t5_pend_after", 64'(pend_cnt), 64'd3);
                chk("t5_rdy", 64'(ifu_arready), 64'd1);
                rst_n = 1'b0;
            end
            tick;
        end
        chk("t5_rst_vld", 64'(ifu_rvalid), 64'd0);
        chk("t5_rst_pend", 64'(pend_cnt), 64'd0);
        chk("t5_rst_rdy", 64'(ifu_arready), 64'd0);
        rst_n = 1'b1;
        ifu_rready = 1'b1;
        beats = 0;
        for (int c = 0; c < 10; c++) begin
            tick;
            if (ifu_rvalid) beats++;
        end
        chk("t5_stale", 64'(beats), 64'd0);

        // LATENCY=3 instance: latency 5, same-cycle backdoor write returns old word
        ifu_arvalid_3 = 1'b1; ifu_araddr_3 = BASE + 64'd20; ifu_rready_3 = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (c == 1) ifu_arvalid_3 = 1'b0;
            if (c == 4) begin
                chk("t6_pre", 64'(ifu_rvalid_3), 64'd0);
                load_en_3 = 1'b1; load_addr_3 = 12'd5; load_data_3 = 32'hAAAA_AAAA;
            end else begin
                load_en_3 = 1'b0;
            end
            if (c == 5) begin
                chk("t6_vld", 64'(ifu_rvalid_3), 64'd1);
                chk("t6_old", 64'(ifu_rdata_3), 64'h5555_5555);
                chk("t6_rsp", 64'(ifu_rresp_3), 64'd0);
            end
            tick;
        end
        load_en_3 = 1'b0;
        ifu_arvalid_3 = 1'b1;
        tick;
        ifu_arvalid_3 = 1'b0;
        n = 1;
        while (!ifu_rvalid_3 && n < 20) begin
            tick;
            n++;
        end
        chk("t6_lat", 64'(n), 64'd5);
        chk("t6_new", 64'(ifu_rdata_3), 64'hAAAA_AAAA);
        tick;
        chk("t6_pend", 64'(pend_cnt_3), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
